// File: rtl/ysyx_24100006_axi_arb_ctrl_pkg.sv
// Shared definitions for the memory-port arbiter: FSM states, read-source tags, grant bit positions.
// No logic here; latency and backpressure are properties of the modules that import it.
package ysyx_24100006_axi_arb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RADDR = 2'd1,
    RDATA = 2'd2,
    WRESP = 2'd3
  } state_t;

  // Round-robin memory of which read requester won most recently.
  typedef enum logic {
    RD_IFU = 1'b0,
    RD_MEM = 1'b1
  } rd_src_t;

  localparam int GNT_IFU  = 0;
  localparam int GNT_MEMR = 1;
  localparam int GNT_WR   = 2;
  localparam int GNT_W    = 3;

endpackage

// File: rtl/ysyx_24100006_arb_pick.sv
// Combinational IDLE-cycle winner: write priority bounded by starvation count, round-robin between reads.
// Latency: zero (pure combinational); no backpressure, the caller samples win only while idle.
module ysyx_24100006_arb_pick
  import ysyx_24100006_axi_arb_ctrl_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int SCNT_W       = 3
) (
  input  logic [GNT_W-1:0]  reqs,
  input  rd_src_t           last_rd,
  input  logic [SCNT_W-1:0] starve_cnt,
  output logic [GNT_W-1:0]  win
);

  logic rd_pend;
  logic wr_ok;

  assign rd_pend = reqs[GNT_IFU] | reqs[GNT_MEMR];
  // A pending read only blocks the write once it has lost STARVE_LIMIT times in a row.
  assign wr_ok   = reqs[GNT_WR] && (!rd_pend || (starve_cnt < SCNT_W'(STARVE_LIMIT)));

  always_comb begin
    win = '0;
    if (wr_ok) begin
      win[GNT_WR] = 1'b1;
    end else if (reqs[GNT_IFU] && reqs[GNT_MEMR]) begin
      if (last_rd == RD_MEM) win[GNT_IFU]  = 1'b1;
      else                   win[GNT_MEMR] = 1'b1;
    end else if (reqs[GNT_IFU]) begin
      win[GNT_IFU] = 1'b1;
    end else if (reqs[GNT_MEMR]) begin
      win[GNT_MEMR] = 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_24100006_axi_arb_ctrl.sv
// Owner/sequence controller for the shared AXI memory port; registered one-hot grant, 1-cycle decision latency.
// Grant held until last R beat or B handshake (optional watchdog under ARB_TIMEOUT_EN); requesters stall while not granted.
module ysyx_24100006_axi_arb_ctrl
  import ysyx_24100006_axi_arb_ctrl_pkg::*;
#(
  parameter int STARVE_LIMIT   = 4
`ifdef ARB_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ifu_req,
  input  logic             mem_rreq,
  input  logic             mem_wreq,
  input  logic             ar_fire,
  input  logic [7:0]       ar_len,
  input  logic             r_fire,
  input  logic             r_last,
  input  logic             b_fire,
  output logic [GNT_W-1:0] grant,
  output logic             busy,
  output logic [7:0]       beat_cnt,
  output logic             burst_err
`ifdef ARB_TIMEOUT_EN
  , output logic           timeout
`endif
);

  localparam int SCNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  state_t            state;
  rd_src_t           last_rd;
  logic [SCNT_W-1:0] starve_cnt;
  logic [7:0]        len_q;
  logic [GNT_W-1:0]  reqs;
  logic [GNT_W-1:0]  win;
  logic              rd_pend;

  assign reqs    = {mem_wreq, mem_rreq, ifu_req};
  assign rd_pend = ifu_req | mem_rreq;
  assign busy    = (state != IDLE);

  ysyx_24100006_arb_pick #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .SCNT_W       (SCNT_W)
  ) u_pick (
    .reqs       (reqs),
    .last_rd    (last_rd),
    .starve_cnt (starve_cnt),
    .win        (win)
  );

`ifdef ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;
  logic        wd_clr;
  logic        wd_hit;

  // Counter restarts on every state change so each phase gets its own budget.
  assign wd_clr = (state == IDLE)
               || ((state == RADDR) && ar_fire)
               || ((state == RDATA) && r_fire && r_last)
               || ((state == WRESP) && b_fire);
  assign wd_hit = (state != IDLE) && (wd_cnt == 16'(TIMEOUT_CYCLES));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      timeout <= !wd_clr && (wd_cnt == 16'(TIMEOUT_CYCLES - 1));
      wd_cnt  <= (wd_clr || wd_hit) ? '0 : wd_cnt + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      grant      <= '0;
      beat_cnt   <= '0;
      burst_err  <= 1'b0;
      starve_cnt <= '0;
      last_rd    <= RD_MEM;
      len_q      <= '0;
    end else begin
      burst_err <= 1'b0;
      unique case (state)
        IDLE: begin
          grant <= win;
          if (win[GNT_WR]) begin
            state <= WRESP;
            if (rd_pend) starve_cnt <= starve_cnt + SCNT_W'(1);
          end else if (win[GNT_IFU] || win[GNT_MEMR]) begin
            state      <= RADDR;
            starve_cnt <= '0;
            last_rd    <= win[GNT_IFU] ? RD_IFU : RD_MEM;
          end
        end
        RADDR: begin
          if (ar_fire) begin
            state    <= RDATA;
            len_q    <= ar_len;
            beat_cnt <= '0;
          end
        end
        RDATA: begin
          if (r_fire) begin
            beat_cnt <= beat_cnt + 8'd1;
            // beat_cnt still holds the index of the beat being accepted.
            if (r_last) begin
              burst_err <= (beat_cnt != len_q);
              state     <= IDLE;
              grant     <= '0;
            end else begin
              burst_err <= (beat_cnt == len_q);
            end
          end
        end
        WRESP: begin
          if (b_fire) begin
            state <= IDLE;
            grant <= '0;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
`ifdef ARB_TIMEOUT_EN
      if (wd_hit) begin
        state <= IDLE;
        grant <= '0;
      end
`endif
    end
  end

endmodule

// File: tb/tb_ysyx_24100006_axi_arb_ctrl.sv
// Scoreboard bench for the memory-port arbiter: expected grants/burst results queued at stimulus, popped at DUT response.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ysyx_24100006_axi_arb_ctrl;
  import ysyx_24100006_axi_arb_ctrl_pkg::*;

  localparam int SL = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       ifu_req, mem_rreq, mem_wreq;
  logic       ar_fire, r_fire, r_last, b_fire;
  logic [7:0] ar_len;
  logic [2:0] grant;
  logic       busy;
  logic [7:0] beat_cnt;
  logic       burst_err;
`ifdef ARB_TIMEOUT_EN
  logic       timeout;
`endif

  always #5 clk = ~clk;

  ysyx_24100006_axi_arb_ctrl #(
    .STARVE_LIMIT (SL)
`ifdef ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES (8)
`endif
  ) u_dut (
    .clk       (clk),
    .reset     (reset),
    .ifu_req   (ifu_req),
    .mem_rreq  (mem_rreq),
    .mem_wreq  (mem_wreq),
    .ar_fire   (ar_fire),
    .ar_len    (ar_len),
    .r_fire    (r_fire),
    .r_last    (r_last),
    .b_fire    (b_fire),
    .grant     (grant),
    .busy      (busy),
    .beat_cnt  (beat_cnt),
    .burst_err (burst_err)
`ifdef ARB_TIMEOUT_EN
    , .timeout (timeout)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  logic [2:0] exp_gnt_q[$];
  int         exp_err_q[$];
  int         exp_beat_q[$];

  rd_src_t m_last;
  int      m_starve;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference arbitration model, advanced once per IDLE decision.
  task automatic model_push(input logic i, input logic m, input logic w);
    logic [2:0] g;
    logic       rd;
    g  = 3'b000;
    rd = i | m;
    if (w && (!rd || m_starve < SL)) begin
      g = 3'b100;
      if (rd) m_starve++;
    end else if (rd) begin
      m_starve = 0;
      if (i && (!m || m_last == RD_MEM)) begin
        g = 3'b001;
        m_last = RD_IFU;
      end else begin
        g = 3'b010;
        m_last = RD_MEM;
      end
    end
    exp_gnt_q.push_back(g);
  endtask

  task automatic wait_grant(output int waited);
    waited = 0;
    while (grant == 3'b000 && waited < 8) begin
      tick();
      waited++;
    end
  endtask

  task automatic serve_read(input int len, input int nbeats, input int last_beat, input bit glitch);
    int         errs;
    int         e_err;
    logic [7:0] bc0;
    logic [2:0] g;
    g = grant;
    chk("busy_rd", busy, 1);
    if (glitch) begin
      bc0 = beat_cnt;
      r_fire = 1; r_last = 1; b_fire = 1;
      tick();
      r_fire = 0; r_last = 0; b_fire = 0;
      chk("ign_raddr_gnt", grant, g);
      chk("ign_raddr_beat", beat_cnt, bc0);
    end
    ar_fire = 1; ar_len = len[7:0];
    tick();
    ar_fire = 0; ar_len = 8'd0;
    e_err = 0;
    for (int b = 0; b < nbeats; b++) begin
      if (b + 1 == last_beat) e_err += ((b % 256) != len) ? 1 : 0;
      else                    e_err += ((b % 256) == len) ? 1 : 0;
    end
    exp_err_q.push_back(e_err);
    exp_beat_q.push_back(nbeats % 256);
    errs = 0;
    for (int b = 0; b < nbeats; b++) begin
      r_fire = 1;
      r_last = (b + 1 == last_beat);
      tick();
      errs += int'(burst_err);
      chk("beat_cnt", beat_cnt, (b + 1) % 256);
      if (b + 1 != last_beat) chk("gnt_hold_rd", grant, g);
    end
    r_fire = 0; r_last = 0;
    chk("gnt_end_rd", grant, 0);
    chk("burst_err_cnt", errs, exp_err_q.pop_front());
    chk("beat_final", beat_cnt, exp_beat_q.pop_front());
  endtask

  task automatic serve_write(input int delay, input bit glitch);
    logic [7:0] bc0;
    bc0 = beat_cnt;
    chk("busy_wr", busy, 1);
    for (int d = 0; d < delay; d++) begin
      if (glitch) begin
        ar_fire = 1; r_fire = 1; r_last = 1;
      end
      tick();
      ar_fire = 0; r_fire = 0; r_last = 0;
      chk("gnt_hold_wr", grant, 3'b100);
    end
    if (glitch) chk("ign_wresp_beat", beat_cnt, bc0);
    b_fire = 1;
    tick();
    b_fire = 0;
    chk("gnt_end_wr", grant, 0);
  endtask

  task automatic run_txn(input int len, input int nbeats, input int last_beat,
                         input bit drop, input bit glitch);
    int         waited;
    logic [2:0] e;
    model_push(ifu_req, mem_rreq, mem_wreq);
    wait_grant(waited);
    chk("gnt_lat", waited, 1);
    e = exp_gnt_q.pop_front();
    chk("gnt", grant, e);
    if (drop) begin
      ifu_req = 0; mem_rreq = 0; mem_wreq = 0;
    end
    if (grant[GNT_WR])      serve_write(2, glitch);
    else if (grant != 3'b0) serve_read(len, nbeats, last_beat, glitch);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_gnt"}, grant, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, burst_err, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int waited;
    logic [2:0] e;
    reset = 0;
    ifu_req = 0; mem_rreq = 0; mem_wreq = 0;
    ar_fire = 0; ar_len = 0; r_fire = 0; r_last = 0; b_fire = 0;
    m_last = RD_MEM; m_starve = 0;
    tick(); tick();
    chk_idle("rst");
    chk("rst_beat", beat_cnt, 0);
`ifdef ARB_TIMEOUT_EN
    chk("rst_to", timeout, 0);
`endif
    reset = 1;
    tick();

    // Single IFU read, len 3, four beats; requester drops after grant.
    ifu_req = 1;
    run_txn(3, 4, 4, 1, 0);
    tick();
    chk_idle("idle1");
    chk("beat_hold", beat_cnt, 4);

    // Burst mismatches: early rlast, then missing rlast with stray inputs in RADDR.
    ifu_req = 1;
    run_txn(1, 1, 1, 1, 0);
    ifu_req = 1;
    run_txn(0, 2, 2, 1, 1);
    tick();
    chk_idle("idle2");

    // Reset in the middle of a data phase; tie after last_rd=IFU goes to MEM first.
    ifu_req = 1; mem_rreq = 1;
    model_push(ifu_req, mem_rreq, mem_wreq);
    wait_grant(waited);
    chk("rst_txn_lat", waited, 1);
    e = exp_gnt_q.pop_front();
    chk("rst_txn_gnt", grant, e);
    ar_fire = 1; ar_len = 8'd3;
    tick();
    ar_fire = 0; r_fire = 1;
    tick(); tick();
    r_fire = 0;
    reset = 0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_beat", beat_cnt, 0);
    m_last = RD_MEM; m_starve = 0;
    exp_gnt_q.delete();
    tick(); tick();
    reset = 1;

    // Both reads held: alternate IFU, MEM, IFU, MEM.
    for (int t = 0; t < 4; t++) run_txn(0, 1, 1, 0, 0);
    ifu_req = 0; mem_rreq = 0;
    tick();
    chk_idle("idle3");

    // Write held with IFU pending: four writes, one forced read, writes resume.
    mem_wreq = 1; ifu_req = 1;
    for (int t = 0; t < 6; t++) run_txn(0, 1, 1, 0, t == 0);
    mem_wreq = 0; ifu_req = 0;
    tick();
    chk_idle("idle4");

    // Lone write, requester drops after grant.
    mem_wreq = 1;
    run_txn(0, 1, 1, 1, 0);
    tick();
    chk_idle("idle5");

`ifdef ARB_TIMEOUT_EN
    // Write with a silent slave: watchdog must reclaim the port.
    mem_wreq = 1;
    model_push(ifu_req, mem_rreq, mem_wreq);
    wait_grant(waited);
    chk("to_lat", waited, 1);
    e = exp_gnt_q.pop_front();
    chk("to_gnt", grant, e);
    mem_wreq = 0;
    for (int c = 0; c < 7; c++) begin
      tick();
      chk("to_early", timeout, 0);
    end
    tick();
    chk("to_pulse", timeout, 1);
    chk("to_gnt_held", grant, 3'b100);
    tick();
    chk("to_gnt_drop", grant, 0);
    chk("to_single", timeout, 0);
    chk("to_busy", busy, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
